i2c_telemetry_responder: RTL and testbench
==========================================

# i2c_telemetry_responder

I2C target (slave) endpoint that lets an external host (ground-station bridge or bench I2C adapter) read flight telemetry from, and write tuning registers to, the drone SOC over a second two-wire bus. It is the responder end of the I2C protocol the SOC already drives as initiator toward the IMU. It decodes START/STOP, matches a 7-bit address, and keeps an auto-incrementing register pointer. It exposes a simple single-port register-bank interface to the rest of the design.

## Interface
- `I2C_ADDR`, 7'h42: 7-bit target address.
- `sys_clk` in 1: system clock (38 MHz); sole clock.
- `rst` in 1: synchronous, active-high reset.
- `scl_in` in 1: raw SCL pad input; asynchronous.
- `sda_in` in 1: raw SDA pad input; asynchronous.
- `sda_oe` out 1: 1 = pull SDA low; 0 = release. Open-drain; the pad is driven by the top level.
- `reg_addr` out 8: current register pointer.
- `reg_rdata` in 8: register bank read data for `reg_addr`, combinational and valid in the same cycle.
- `wr_strobe` out 1: one-cycle write pulse.
- `wr_data` out 8: write data, valid while `wr_strobe` is high.
- `busy` out 1: high from address match until STOP, START, or NACK.

## Operation
- **Line sync:** each line passes through a 2-flop synchronizer, then a registered copy for edge detection.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
- **Bit timing:** bits are sampled on SCL rising edges. `sda_oe` changes only on SCL falling edges.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- **START:** from any state, go to ADDR, clear the bit counter, release SDA. This covers repeated START.
- **STOP:** from any state, go to IDLE, release SDA, drop `busy`.
- **ADDR:** shift 8 bits, MSB first.
  - Address match, R/W=0 → ADDR_ACK, then PTR.
  - Address match, R/W=1 → ADDR_ACK, then RDATA.
  - Mismatch → WAIT_STOP. No ACK, no strobes, `busy` stays 0.
- **ACK slot:** at the SCL fall after the 8th bit, assert `sda_oe`. At the following SCL fall, release it, or drive the first read bit if entering RDATA.
- **PTR:** the received byte loads `reg_addr`.
- **WDATA:**
  - After each 8th bit, pulse `wr_strobe` for 1 cycle with `wr_data` = byte and `reg_addr` = pointer.
  - Increment `reg_addr` on the cycle after the strobe.
  - The ACK is then driven as usual. Repeats until STOP or START.
- **RDATA:**
  - On entry, and after each host ACK, latch `reg_rdata` into the TX shift register at the SCL fall that begins the byte.
  - Drive `sda_oe = ~bit` (MSB first).
- **RDATA_ACK:** release SDA and sample the host bit at the 9th SCL rise.
  - 0 (ACK): increment `reg_addr`, go to RDATA.
  - 1 (NACK): go to WAIT_STOP and drop `busy`.
- **Pointer:** 8-bit, wraps 8'hFF → 8'h00 on both read and write. The pointer persists across transactions until rewritten or reset.
- **Byte framing:** 9 bits per byte (8 data + ACK). A START or STOP mid-byte aborts the byte; no partial write strobe is issued.
- **No clock stretching:** SCL is never driven.

## Timing
- **Reset values:** `sda_oe`=0, `wr_strobe`=0, `wr_data`=0, `reg_addr`=0, `busy`=0; state IDLE; synchronizer flops = 1 (bus idle).
- Reset asserted mid-transaction releases SDA on the next `sys_clk` edge.
- **Latency:** pad edge to detected event = 3 `sys_clk` cycles. `sda_oe` update = event + 1 cycle, i.e. ≤ 4 cycles (105 ns) after the pad SCL fall. This meets the I2C tHD;DAT ≥ 0.
- **Clock ratio:** `sys_clk` ≥ 16× SCL (guaranteed up to 400 kHz). SCL high and low phases are each ≥ 4 `sys_clk` cycles.
- **Write path:** `wr_strobe` is asserted 1 cycle after the 8th-bit rise is detected.
- **Read path:** `reg_rdata` is sampled in the same cycle the SCL fall is detected.
- **Simultaneous SDA and SCL edges** in one cycle: treated as a data bit change, never as START/STOP.

## Structure
- **`common_defines.v`:**
  - `` `I2C_RESP_DEFAULT_ADDR `` (7'h42)
  - State encodings `` `I2C_ST_* `` (4-bit)
  - `` `I2C_BITS_PER_BYTE `` (8)
- **Sub-module `i2c_line_sync`:** 2-flop sync plus edge detection for one line. It has outputs `level`, `rise`, `fall` and is instanced twice (SCL, SDA).
- **Top FSM:** shift registers, bit counter (4-bit), and pointer live in the top module.

## Test plan
- **Single write:** write to 0x42 with pointer 0x10, data 0xA5, STOP → ACK on all three bytes; exactly one `wr_strobe` with `reg_addr`=0x10, `wr_data`=0xA5; `reg_addr`=0x11 afterward.
- **Write then read with repeated START:** pointer 0x05, repeated START, read 3 bytes (ACK, ACK, NACK), bank returns `reg_addr`+0x30 → host sees 0x35, 0x36, 0x37; `reg_addr` ends at 0x07; no `wr_strobe`.
- **Wrong address:** access to 0x43 with 4 data bytes → `sda_oe` never asserted, no `wr_strobe`, `busy`=0 throughout.
- **Pointer wrap:** pointer 0xFF, write 0x11, 0x22 → strobes at addresses 0xFF then 0x00.
- **Aborted byte:** STOP after 5 data bits of a write byte → no `wr_strobe`, state IDLE, next transaction ACKed normally.
- **Reset mid-read:** assert `rst` while driving a 0 bit → `sda_oe`=0 the next cycle, all outputs at reset values, next START decodes correctly.

Source files
------------

// File: rtl/i2c_telemetry_responder_pkg.sv
// Shared definitions for the I2C telemetry responder: default target address,
// byte framing constant, FSM state type and an address-match helper.
package i2c_telemetry_responder_pkg;

  localparam logic [6:0]  DEFAULT_ADDR  = 7'h42;
  localparam int unsigned BITS_PER_BYTE = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  // True when the upper seven bits of an address byte select this target.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] target);
    return addr_byte[7:1] == target;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one asynchronous bus line, followed by a registered
// copy so that single-cycle rise/fall strobes can be formed.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pad_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain; resets to 1 because an idle I2C line is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= pad_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/i2c_telemetry_responder.sv
// I2C target endpoint: START/STOP decode, 7-bit address match, auto-incrementing
// register pointer and a single-port register-bank interface.
module i2c_telemetry_responder
  import i2c_telemetry_responder_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = DEFAULT_ADDR
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_rdata,
  output logic       wr_strobe,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [3:0] LAST_BIT  = 4'(BITS_PER_BYTE - 1);
  localparam logic [3:0] BYTE_DONE = 4'(BITS_PER_BYTE);
  localparam logic [3:0] HOST_ACKD = 4'(BITS_PER_BYTE + 1);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_byte;

  state_t     r_state,     w_state_nxt;
  logic [3:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic [7:0] r_rx,        w_rx_nxt;
  logic [7:0] r_tx,        w_tx_nxt;
  logic       r_rw,        w_rw_nxt;
  logic       r_sda_oe,    w_sda_oe_nxt;
  logic       r_busy,      w_busy_nxt;
  logic [7:0] r_reg_addr,  w_reg_addr_nxt;
  logic       r_wr_strobe, w_wr_strobe_nxt;
  logic [7:0] r_wr_data,   w_wr_data_nxt;

  i2c_line_sync u_scl_sync (
    .clk    (sys_clk),
    .rst    (rst),
    .pad_in (scl_in),
    .level  (w_scl_lvl),
    .rise   (w_scl_rise),
    .fall   (w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk    (sys_clk),
    .rst    (rst),
    .pad_in (sda_in),
    .level  (w_sda_lvl),
    .rise   (w_sda_rise),
    .fall   (w_sda_fall)
  );

  // An SDA edge coinciding with an SCL edge is a data change, not a condition.
  assign w_start = w_sda_fall & w_scl_lvl & ~w_scl_rise & ~w_scl_fall;
  assign w_stop  = w_sda_rise & w_scl_lvl & ~w_scl_rise & ~w_scl_fall;
  assign w_byte  = {r_rx[6:0], w_sda_lvl};

  // State and datapath registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_reg_addr  <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_rx        <= w_rx_nxt;
      r_tx        <= w_tx_nxt;
      r_rw        <= w_rw_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_wr_data   <= w_wr_data_nxt;
    end
  end

  // Next-state and datapath decode driven by synchronized bus events.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_rx_nxt        = r_rx;
    w_tx_nxt        = r_tx;
    w_rw_nxt        = r_rw;
    w_sda_oe_nxt    = r_sda_oe;
    w_busy_nxt      = r_busy;
    // The pointer advances on the cycle after a write strobe.
    w_reg_addr_nxt  = r_wr_strobe ? r_reg_addr + 8'd1 : r_reg_addr;
    w_wr_strobe_nxt = 1'b0;
    w_wr_data_nxt   = r_wr_data;

    if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ST_ADDR;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_rx_nxt      = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == LAST_BIT) begin
              w_bit_cnt_nxt = '0;
              if (addr_match(w_byte, I2C_ADDR)) begin
                w_state_nxt = ST_ADDR_ACK;
                w_rw_nxt    = w_byte[0];
                w_busy_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_WAIT_STOP;
              end
            end
          end
        end

        // ACK slots: first SCL fall pulls SDA low (r_sda_oe doubles as the
        // "ACK already driven" flag), the second fall ends the slot.
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else if (r_rw) begin
              w_state_nxt   = ST_RDATA;
              w_tx_nxt      = reg_rdata;
              w_sda_oe_nxt  = ~reg_rdata[7];
              w_bit_cnt_nxt = '0;
            end else begin
              w_state_nxt  = ST_PTR;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end

        ST_PTR: begin
          if (w_scl_rise) begin
            w_rx_nxt      = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == LAST_BIT) begin
              w_bit_cnt_nxt  = '0;
              w_reg_addr_nxt = w_byte;
              w_state_nxt    = ST_PTR_ACK;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_state_nxt  = ST_WDATA;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end

        ST_WDATA: begin
          if (w_scl_rise) begin
            w_rx_nxt      = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == LAST_BIT) begin
              w_bit_cnt_nxt   = '0;
              w_wr_strobe_nxt = 1'b1;
              w_wr_data_nxt   = w_byte;
              w_state_nxt     = ST_WDATA_ACK;
            end
          end
        end

        ST_RDATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == BYTE_DONE) begin
              w_state_nxt  = ST_RDATA_ACK;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_tx_nxt     = {r_tx[6:0], 1'b0};
              w_sda_oe_nxt = ~r_tx[6];
            end
          end
        end

        // Bit counter value HOST_ACKD marks "host ACKed, reload at next fall".
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda_lvl) begin
              w_bit_cnt_nxt  = HOST_ACKD;
              w_reg_addr_nxt = r_reg_addr + 8'd1;
            end else begin
              w_state_nxt = ST_WAIT_STOP;
              w_busy_nxt  = 1'b0;
            end
          end else if (w_scl_fall && r_bit_cnt == HOST_ACKD) begin
            w_state_nxt   = ST_RDATA;
            w_tx_nxt      = reg_rdata;
            w_sda_oe_nxt  = ~reg_rdata[7];
            w_bit_cnt_nxt = '0;
          end
        end

        ST_IDLE, ST_WAIT_STOP: ;

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_addr  = r_reg_addr;
  assign wr_strobe = r_wr_strobe;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_telemetry_responder.sv
// Self-checking bench: a bit-level I2C host drives the responder over a
// wired-AND SDA; a behavioural pointer/bank model predicts reads and writes.
module tb_i2c_telemetry_responder;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       scl_host = 1'b1;
  logic       sda_host = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_rdata;
  logic       wr_strobe;
  logic [7:0] wr_data;
  logic       busy;

  logic [7:0] bank [256];

  int n_checks = 0;
  int n_errors = 0;

  // Write-strobe log and activity counters, written only by the monitor.
  logic [7:0] st_addr [4096];
  logic [7:0] st_data [4096];
  int         st_n     = 0;
  int         oe_cnt   = 0;
  int         busy_cnt = 0;

  logic [7:0] m_ptr = 8'h00;

  always #5 sys_clk = ~sys_clk;

  assign sda_bus   = sda_host & ~sda_oe;
  assign reg_rdata = bank[reg_addr];

  i2c_telemetry_responder #(.I2C_ADDR(7'h42)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .scl_in    (scl_host),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .wr_strobe (wr_strobe),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always @(negedge sys_clk) begin
    if (wr_strobe === 1'b1) begin
      st_addr[st_n] <= reg_addr;
      st_data[st_n] <= wr_data;
      st_n <= st_n + 1;
    end
    if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Bus primitives; each data bit starts and ends with SCL low.
  task automatic host_bit_out(input logic b);
    cyc(4); sda_host = b; cyc(8);
    scl_host = 1'b1; cyc(12);
    scl_host = 1'b0;
  endtask

  task automatic host_bit_in(output logic b);
    cyc(4); sda_host = 1'b1; cyc(8);
    scl_host = 1'b1; cyc(6);
    b = sda_bus; cyc(6);
    scl_host = 1'b0;
  endtask

  task automatic host_start();
    if (scl_host == 1'b0) begin
      cyc(4); sda_host = 1'b1; cyc(8);
      scl_host = 1'b1;
    end
    cyc(6); sda_host = 1'b0; cyc(6);
    scl_host = 1'b0;
  endtask

  task automatic host_stop();
    cyc(4); sda_host = 1'b0; cyc(8);
    scl_host = 1'b1; cyc(6);
    sda_host = 1'b1; cyc(12);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic nack);
    for (int i = 7; i >= 0; i--) host_bit_out(b[i]);
    host_bit_in(nack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) host_bit_in(d[i]);
    host_bit_out(nack);
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(5); rst = 1'b0; cyc(2);
    n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_checks++; if (wr_strobe !== 1'b0) begin n_errors++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    n_checks++; if (wr_data !== 8'h00) begin n_errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_checks++; if (reg_addr !== 8'h00) begin n_errors++; $display("FAIL reset_reg_addr: got %h want 00", reg_addr); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    m_ptr = 8'h00;
  endtask

  task automatic test_single_write();
    logic nk;
    int s0 = st_n;
    host_start();
    write_byte(8'h84, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL sw_addr_ack: got %b want 0", nk); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL sw_busy: got %b want 1", busy); end
    write_byte(8'h10, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL sw_ptr_ack: got %b want 0", nk); end
    write_byte(8'hA5, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL sw_data_ack: got %b want 0", nk); end
    host_stop(); cyc(4);
    n_checks++; if (st_n - s0 !== 1) begin n_errors++; $display("FAIL sw_strobe_count: got %0d want 1", st_n - s0); end
    if (st_n - s0 >= 1) begin
      n_checks++; if (st_addr[s0] !== 8'h10) begin n_errors++; $display("FAIL sw_strobe_addr: got %h want 10", st_addr[s0]); end
      n_checks++; if (st_data[s0] !== 8'hA5) begin n_errors++; $display("FAIL sw_strobe_data: got %h want a5", st_data[s0]); end
    end
    n_checks++; if (reg_addr !== 8'h11) begin n_errors++; $display("FAIL sw_ptr_after: got %h want 11", reg_addr); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL sw_busy_after_stop: got %b want 0", busy); end
    m_ptr = 8'h11;
  endtask

  task automatic test_write_read_rs();
    logic nk;
    logic [7:0] d;
    logic [7:0] exp_d [3];
    int s0 = st_n;
    for (int i = 0; i < 256; i++) bank[i] = 8'(i + 8'h30);
    exp_d[0] = 8'h35; exp_d[1] = 8'h36; exp_d[2] = 8'h37;
    host_start();
    write_byte(8'h84, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL rs_waddr_ack: got %b want 0", nk); end
    write_byte(8'h05, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL rs_ptr_ack: got %b want 0", nk); end
    host_start();
    write_byte(8'h85, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL rs_raddr_ack: got %b want 0", nk); end
    for (int i = 0; i < 3; i++) begin
      read_byte((i == 2), d);
      n_checks++; if (d !== exp_d[i]) begin n_errors++; $display("FAIL rs_read%0d: got %h want %h", i, d, exp_d[i]); end
    end
    cyc(6);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rs_busy_after_nack: got %b want 0", busy); end
    host_stop(); cyc(4);
    n_checks++; if (reg_addr !== 8'h07) begin n_errors++; $display("FAIL rs_ptr_after: got %h want 07", reg_addr); end
    n_checks++; if (st_n !== s0) begin n_errors++; $display("FAIL rs_no_strobe: got %0d strobes want 0", st_n - s0); end
    m_ptr = 8'h07;
  endtask

  task automatic test_wrong_addr();
    logic nk;
    int s0 = st_n;
    int o0 = oe_cnt;
    int b0 = busy_cnt;
    host_start();
    write_byte(8'h86, nk);
    n_checks++; if (nk !== 1'b1) begin n_errors++; $display("FAIL wa_addr_nack: got %b want 1", nk); end
    for (int i = 0; i < 4; i++) begin
      write_byte(8'($urandom), nk);
      n_checks++; if (nk !== 1'b1) begin n_errors++; $display("FAIL wa_data%0d_nack: got %b want 1", i, nk); end
    end
    host_stop(); cyc(4);
    n_checks++; if (oe_cnt !== o0) begin n_errors++; $display("FAIL wa_sda_oe: got %0d asserted cycles want 0", oe_cnt - o0); end
    n_checks++; if (busy_cnt !== b0) begin n_errors++; $display("FAIL wa_busy: got %0d busy cycles want 0", busy_cnt - b0); end
    n_checks++; if (st_n !== s0) begin n_errors++; $display("FAIL wa_strobe: got %0d strobes want 0", st_n - s0); end
    n_checks++; if (reg_addr !== m_ptr) begin n_errors++; $display("FAIL wa_ptr: got %h want %h", reg_addr, m_ptr); end
  endtask

  task automatic test_ptr_wrap();
    logic nk;
    int s0 = st_n;
    host_start();
    write_byte(8'h84, nk);
    write_byte(8'hFF, nk);
    write_byte(8'h11, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL wrap_ack0: got %b want 0", nk); end
    write_byte(8'h22, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL wrap_ack1: got %b want 0", nk); end
    host_stop(); cyc(4);
    n_checks++; if (st_n - s0 !== 2) begin n_errors++; $display("FAIL wrap_count: got %0d want 2", st_n - s0); end
    if (st_n - s0 >= 2) begin
      n_checks++; if (st_addr[s0] !== 8'hFF || st_data[s0] !== 8'h11) begin n_errors++; $display("FAIL wrap_first: got %h/%h want ff/11", st_addr[s0], st_data[s0]); end
      n_checks++; if (st_addr[s0+1] !== 8'h00 || st_data[s0+1] !== 8'h22) begin n_errors++; $display("FAIL wrap_second: got %h/%h want 00/22", st_addr[s0+1], st_data[s0+1]); end
    end
    n_checks++; if (reg_addr !== 8'h01) begin n_errors++; $display("FAIL wrap_ptr: got %h want 01", reg_addr); end
    m_ptr = 8'h01;
  endtask

  task automatic test_abort();
    logic nk;
    int s0 = st_n;
    host_start();
    write_byte(8'h84, nk);
    write_byte(8'h20, nk);
    for (int i = 0; i < 5; i++) host_bit_out(1'($urandom));
    host_stop(); cyc(4);
    n_checks++; if (st_n !== s0) begin n_errors++; $display("FAIL abort_strobe: got %0d strobes want 0", st_n - s0); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (reg_addr !== 8'h20) begin n_errors++; $display("FAIL abort_ptr: got %h want 20", reg_addr); end
    host_start();
    write_byte(8'h84, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL abort_next_ack: got %b want 0", nk); end
    write_byte(8'h30, nk);
    write_byte(8'h5A, nk);
    host_stop(); cyc(4);
    n_checks++; if (st_n - s0 !== 1 || st_addr[s0] !== 8'h30 || st_data[s0] !== 8'h5A) begin
      n_errors++; $display("FAIL abort_next_write: got %0d strobes %h/%h want 1 30/5a", st_n - s0, st_addr[s0], st_data[s0]);
    end
    m_ptr = 8'h31;
  endtask

  task automatic test_reset_mid_read();
    logic nk;
    int s0;
    int waited = 0;
    bank[8'h50] = 8'h00;
    host_start();
    write_byte(8'h84, nk);
    write_byte(8'h50, nk);
    host_start();
    write_byte(8'h85, nk);
    while (sda_oe !== 1'b1 && waited < 40) begin cyc(1); waited++; end
    n_checks++; if (sda_oe !== 1'b1) begin n_errors++; $display("FAIL rmr_drive_zero: got %b want 1 within 40 cycles", sda_oe); end
    rst = 1'b1;
    cyc(1);
    n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL rmr_sda_release: got %b want 0", sda_oe); end
    n_checks++; if (busy !== 1'b0 || wr_strobe !== 1'b0 || wr_data !== 8'h00 || reg_addr !== 8'h00) begin
      n_errors++; $display("FAIL rmr_outputs: got busy=%b strobe=%b data=%h addr=%h want 0/0/00/00", busy, wr_strobe, wr_data, reg_addr);
    end
    cyc(2); rst = 1'b0; cyc(4);
    m_ptr = 8'h00;
    s0 = st_n;
    host_start();
    write_byte(8'h84, nk);
    n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL rmr_after_ack: got %b want 0", nk); end
    write_byte(8'h40, nk);
    write_byte(8'h77, nk);
    host_stop(); cyc(4);
    n_checks++; if (st_n - s0 !== 1 || st_addr[s0] !== 8'h40 || st_data[s0] !== 8'h77) begin
      n_errors++; $display("FAIL rmr_after_write: got %0d strobes %h/%h want 1 40/77", st_n - s0, st_addr[s0], st_data[s0]);
    end
    m_ptr = 8'h41;
  endtask

  // Random mix of writes, pointer-set reads, current-pointer reads and
  // foreign-address accesses, predicted from pointer arithmetic and the bank.
  task automatic test_random();
    logic nk;
    logic [7:0] d, p, ev;
    int kind, n, s0;
    logic [7:0] exp_a [$];
    logic [7:0] exp_v [$];
    for (int i = 0; i < 256; i++) bank[i] = 8'($urandom);
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      s0 = st_n;
      exp_a.delete(); exp_v.delete();
      host_start();
      if (kind == 0) begin
        p = 8'($urandom);
        write_byte(8'h84, nk);
        write_byte(p, nk);
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          exp_a.push_back(8'(p + 8'(i)));
          exp_v.push_back(d);
          write_byte(d, nk);
          n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_wack%0d: got %b want 0", t, i, nk); end
        end
        m_ptr = 8'(p + 8'(n));
      end else if (kind == 1 || kind == 2) begin
        if (kind == 1) begin
          m_ptr = 8'($urandom);
          write_byte(8'h84, nk);
          write_byte(m_ptr, nk);
          host_start();
        end
        write_byte(8'h85, nk);
        n_checks++; if (nk !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_raddr_ack: got %b want 0", t, nk); end
        for (int i = 0; i < n; i++) begin
          ev = bank[8'(m_ptr + 8'(i))];
          read_byte((i == n - 1), d);
          n_checks++; if (d !== ev) begin n_errors++; $display("FAIL rnd%0d_read%0d: got %h want %h", t, i, d, ev); end
        end
        m_ptr = 8'(m_ptr + 8'(n - 1));
      end else begin
        p = {7'($urandom_range(0, 127)), 1'b0};
        if (p[7:1] == 7'h42) p = 8'h10;
        write_byte(p, nk);
        n_checks++; if (nk !== 1'b1) begin n_errors++; $display("FAIL rnd%0d_foreign_nack: got %b want 1", t, nk); end
        for (int i = 0; i < n; i++) write_byte(8'($urandom), nk);
      end
      host_stop(); cyc(4);
      n_checks++; if (st_n - s0 !== exp_a.size()) begin n_errors++; $display("FAIL rnd%0d_strobe_count: got %0d want %0d", t, st_n - s0, exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < st_n - s0; i++) begin
        n_checks++; if (st_addr[s0+i] !== exp_a[i] || st_data[s0+i] !== exp_v[i]) begin
          n_errors++; $display("FAIL rnd%0d_strobe%0d: got %h/%h want %h/%h", t, i, st_addr[s0+i], st_data[s0+i], exp_a[i], exp_v[i]);
        end
      end
      n_checks++; if (reg_addr !== m_ptr) begin n_errors++; $display("FAIL rnd%0d_ptr: got %h want %h", t, reg_addr, m_ptr); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bank[i] = 8'h00;
    test_reset();
    test_single_write();
    test_write_read_rs();
    test_wrong_addr();
    test_ptr_wrap();
    test_abort();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
